// File: rtl/botsys_reader_pkg.sv
// Shared types and constants for the Rojobot register reader.
// The snapshot layout and the MotCtl field layout are defined here as packed structs.
package botsys_reader_pkg;

  typedef struct packed {
    logic [7:0] loc_x;
    logic [7:0] loc_y;
    logic [7:0] bot_info;
    logic [7:0] sensors;
  } snap_t;

  typedef struct packed {
    logic [2:0] lm_spd;
    logic       lm_dir;
    logic [2:0] rm_spd;
    logic       rm_dir;
  } mot_ctl_t;

  localparam int SNAP_W = $bits(snap_t);

  localparam logic [7:0] MOT_STOP = 8'h00;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALE = 1'b1
  } wd_state_e;

endpackage

// File: rtl/botsys_reader_snap_fifo.sv
// Generic synchronous FIFO with registered storage and no fall-through.
// When the FIFO is full, a push is accepted only if a pop happens on the same edge.
module snap_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

  // An empty FIFO reports zero so the head is defined out of reset.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/botsys_reader.sv
// Rojobot register consumer: snapshots each BOTSIM update into a FIFO and owns MotCtl,
// forcing the motors to stop when updates go stale.
module botsys_reader
  import botsys_reader_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 5000000,
  parameter int TMR_W   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_sysregs,
  input  logic [7:0]  LocX,
  input  logic [7:0]  LocY,
  input  logic [7:0]  BotInfo,
  input  logic [7:0]  Sensors,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic [31:0] snap_data,
  input  logic [7:0]  mot_cmd,
  input  logic        mot_cmd_wr,
  output logic [7:0]  MotCtl,
  output logic        stale,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic [7:0]  drop_cnt,
  output logic [15:0] upd_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             upd_q;
  logic             upd_evt;
  logic             pop, push, drop;
  snap_t            push_snap;
  logic [SNAP_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  wd_state_e   state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]  mot_reg_q, mot_reg_d;
  logic [7:0]  motctl_q, motctl_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [15:0] upd_cnt_q, upd_cnt_d;

  assign upd_evt = upd_sysregs ^ upd_q;

  assign push_snap = '{loc_x: LocX, loc_y: LocY, bot_info: BotInfo, sensors: Sensors};

  assign pop  = snap_valid & snap_ready;
  assign push = upd_evt & ((fifo_count < CNT_W'(DEPTH)) | pop);
  assign drop = upd_evt & fifo_full & ~pop;

  snap_fifo #(
    .WIDTH(SNAP_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(push_snap),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign snap_valid = ~fifo_empty;
  assign snap_data  = fifo_head;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mot_reg_d  = mot_reg_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    upd_cnt_d  = upd_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (upd_evt) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d   = ST_STALE;
          timer_d   = '0;
          mot_reg_d = MOT_STOP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_STALE: begin
        if (upd_evt) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
    endcase

    // A write on the edge that enters STALE still lands in mot_reg; MotCtl stays stopped.
    if (mot_cmd_wr) mot_reg_d = mot_cmd;
    motctl_d = (state_d == ST_STALE) ? MOT_STOP : mot_reg_d;

    if (upd_evt) upd_cnt_d = upd_cnt_q + 16'd1;

    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // upd_q follows the flag even in reset so reset exit never looks like a toggle.
  always_ff @(posedge clk) begin
    upd_q <= upd_sysregs;
    if (!reset) begin
      state_q    <= ST_RUN;
      timer_q    <= '0;
      mot_reg_q  <= MOT_STOP;
      motctl_q   <= MOT_STOP;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
      upd_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mot_reg_q  <= mot_reg_d;
      motctl_q   <= motctl_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      upd_cnt_q  <= upd_cnt_d;
    end
  end

  assign MotCtl   = motctl_q;
  assign stale    = (state_q == ST_STALE);
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
  assign upd_cnt  = upd_cnt_q;

endmodule

// File: tb/tb_botsys_reader.sv
// Self-checking bench for botsys_reader: a queue-based behavioural model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_botsys_reader;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_sysregs;
  logic [7:0]  LocX, LocY, BotInfo, Sensors;
  logic        snap_valid;
  logic        snap_ready;
  logic [31:0] snap_data;
  logic [7:0]  mot_cmd;
  logic        mot_cmd_wr;
  logic [7:0]  MotCtl;
  logic        stale;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;
  logic [15:0] upd_cnt;

  int checks = 0;
  int errors = 0;

  botsys_reader #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .TMR_W  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .upd_sysregs(upd_sysregs),
    .LocX       (LocX),
    .LocY       (LocY),
    .BotInfo    (BotInfo),
    .Sensors    (Sensors),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .snap_data  (snap_data),
    .mot_cmd    (mot_cmd),
    .mot_cmd_wr (mot_cmd_wr),
    .MotCtl     (MotCtl),
    .stale      (stale),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt),
    .upd_cnt    (upd_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_q[$];
  bit          m_started = 0;
  logic        m_prev;
  int          m_quiet;
  bit          m_stale;
  logic [7:0]  m_mot, m_motctl;
  bit          m_ovf;
  int          m_drop;
  int          m_upd;

  always @(posedge clk) begin
    bit evt, pop, was_full, dropped;
    if (!reset) begin
      m_q.delete();
      m_started = 1;
      m_prev    = upd_sysregs;
      m_quiet   = 0;
      m_stale   = 0;
      m_mot     = 8'h00;
      m_motctl  = 8'h00;
      m_ovf     = 0;
      m_drop    = 0;
      m_upd     = 0;
    end else if (m_started) begin
      evt      = (upd_sysregs !== m_prev);
      m_prev   = upd_sysregs;
      was_full = (m_q.size() == DEPTH);
      pop      = (m_q.size() > 0) && snap_ready;
      dropped  = evt && was_full && !pop;
      if (pop) void'(m_q.pop_front());
      if (evt) begin
        m_upd = (m_upd + 1) % 65536;
        if (!dropped) m_q.push_back({LocX, LocY, BotInfo, Sensors});
      end
      if (dropped) begin
        m_ovf  = 1;
        m_drop = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (ovf_clr) begin
        m_ovf  = 0;
        m_drop = 0;
      end
      // Stale once TIMEOUT consecutive cycles have passed with no update.
      if (evt) begin
        m_quiet = 0;
        m_stale = 0;
      end else if (!m_stale) begin
        m_quiet++;
        if (m_quiet >= TIMEOUT) begin
          m_stale = 1;
          m_mot   = 8'h00;
        end
      end
      if (mot_cmd_wr) m_mot = mot_cmd;
      m_motctl = m_stale ? 8'h00 : m_mot;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("snap_valid", 32'(snap_valid), 32'(m_q.size() > 0));
      check("snap_data",  snap_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
      check("MotCtl",     32'(MotCtl), 32'(m_motctl));
      check("stale",      32'(stale), 32'(m_stale));
      check("ovf",        32'(ovf), 32'(m_ovf));
      check("drop_cnt",   32'(drop_cnt), 32'(m_drop));
      check("upd_cnt",    32'(upd_cnt), 32'(m_upd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic toggle(input logic [7:0] x);
    LocX        = x;
    upd_sysregs = ~upd_sysregs;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; upd_sysregs = 1'b0;
    LocX = 8'd0; LocY = 8'd20; BotInfo = 8'h03; Sensors = 8'h18;
    snap_ready = 1'b0; mot_cmd = 8'h00; mot_cmd_wr = 1'b0; ovf_clr = 1'b0;
    cyc(2);
    check("reset snap_valid", 32'(snap_valid), 32'h0);
    check("reset MotCtl",     32'(MotCtl), 32'h0);
    check("reset upd_cnt",    32'(upd_cnt), 32'h0);
    check("reset stale",      32'(stale), 32'h0);
    reset = 1'b1;

    // Three updates, consumer always ready.
    snap_ready = 1'b1;
    toggle(8'd10);
    check("t1 first snap", snap_data, 32'h0A140318);
    toggle(8'd11);
    check("t1 second snap", snap_data, 32'h0B140318);
    toggle(8'd12);
    check("t1 third snap", snap_data, 32'h0C140318);
    cyc(1);
    check("t1 drained", 32'(snap_valid), 32'h0);
    check("t1 upd_cnt", 32'(upd_cnt), 32'd3);
    check("t1 ovf",     32'(ovf), 32'h0);

    // Overflow with a stalled consumer.
    do_reset();
    snap_ready = 1'b0;
    for (int i = 0; i < 6; i++) toggle(8'h20 + 8'(i));
    check("t2 head kept", snap_data, 32'h20140318);
    check("t2 ovf",       32'(ovf), 32'h1);
    check("t2 drop_cnt",  32'(drop_cnt), 32'd2);
    check("t2 upd_cnt",   32'(upd_cnt), 32'd6);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("t2 clr ovf",   32'(ovf), 32'h0);
    check("t2 clr drops", 32'(drop_cnt), 32'h0);

    // Full FIFO: push and pop on the same edge, then drop-vs-clear priority.
    snap_ready = 1'b1;
    toggle(8'h30);
    snap_ready = 1'b0;
    check("t3 head advanced", snap_data, 32'h21140318);
    check("t3 no drop",       32'(drop_cnt), 32'h0);
    toggle(8'h31);
    check("t3 still full drop", 32'(drop_cnt), 32'd1);
    ovf_clr = 1'b1;
    toggle(8'h32);
    ovf_clr = 1'b0;
    check("t3 drop wins cnt", 32'(drop_cnt), 32'd1);
    check("t3 drop wins ovf", 32'(ovf), 32'h1);
    snap_ready = 1'b1;
    cyc(3);
    check("t3 tail entry", snap_data, 32'h30140318);
    cyc(1);
    check("t3 empty", 32'(snap_valid), 32'h0);

    // Watchdog.
    do_reset();
    toggle(8'h40);
    mot_cmd = 8'hE7; mot_cmd_wr = 1'b1; cyc(1); mot_cmd_wr = 1'b0;
    check("t4 MotCtl write", 32'(MotCtl), 32'hE7);
    cyc(14);
    check("t4 not yet stale", 32'(stale), 32'h0);
    cyc(1);
    check("t4 stale",        32'(stale), 32'h1);
    check("t4 stale MotCtl", 32'(MotCtl), 32'h0);
    toggle(8'h41);
    check("t4 run again",  32'(stale), 32'h0);
    check("t4 MotCtl off", 32'(MotCtl), 32'h0);
    mot_cmd = 8'h5A; mot_cmd_wr = 1'b1; cyc(1); mot_cmd_wr = 1'b0;
    check("t4 MotCtl 5A", 32'(MotCtl), 32'h5A);
    cyc(14);
    mot_cmd = 8'h3C; mot_cmd_wr = 1'b1; cyc(1); mot_cmd_wr = 1'b0;
    check("t4 write on stale entry", 32'(MotCtl), 32'h0);
    check("t4 stale with write",     32'(stale), 32'h1);
    toggle(8'h42);
    check("t4 written cmd shows", 32'(MotCtl), 32'h3C);

    // Flag held high through reset.
    reset = 1'b0; upd_sysregs = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    check("t5 no push", 32'(snap_valid), 32'h0);
    check("t5 upd_cnt", 32'(upd_cnt), 32'h0);

    // Reset mid-stream.
    snap_ready = 1'b0;
    toggle(8'h50);
    toggle(8'h51);
    mot_cmd = 8'h55; mot_cmd_wr = 1'b1; cyc(1); mot_cmd_wr = 1'b0;
    check("t6 queued",  32'(snap_valid), 32'h1);
    check("t6 MotCtl",  32'(MotCtl), 32'h55);
    reset = 1'b0; cyc(1);
    check("t6 snap_valid", 32'(snap_valid), 32'h0);
    check("t6 MotCtl 0",   32'(MotCtl), 32'h0);
    check("t6 upd_cnt 0",  32'(upd_cnt), 32'h0);
    check("t6 drop_cnt 0", 32'(drop_cnt), 32'h0);
    reset = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/botsys_reader.md
Name: botsys_reader

Overview:
- Application-side consumer of the Rojobot system register interface.
- Detects each toggle of the BOTSIM update flag and captures a consistent snapshot of LocX/LocY/BotInfo/Sensors into a small FIFO.
- Presents snapshots to application logic over a valid/ready handshake.
- Owns the MotCtl register driven back to BOTSIM, with a staleness watchdog that forces the motors to stop if updates cease.

Parameters:
- DEPTH, 4: snapshot FIFO entries; power of two, ≥2.
- TIMEOUT, 5000000: cycles without an update before entering STALE (50 ms at 100 MHz); must be ≥1.
- TMR_W, 24: watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- upd_sysregs  in  1  update flag from BOTSIM interface; every toggle means new registers are valid
- LocX  in  8  bot X coordinate
- LocY  in  8  bot Y coordinate
- BotInfo  in  8  orientation/movement
- Sensors  in  8  proximity/line sensors
- snap_valid  out  1  FIFO head is valid
- snap_ready  in  1  consumer accepts head
- snap_data  out  32  head entry {LocX,LocY,BotInfo,Sensors}, LocX in [31:24]
- mot_cmd  in  8  motor command {lm_spd[2:0],lm_dir,rm_spd[2:0],rm_dir}
- mot_cmd_wr  in  1  write strobe for mot_cmd
- MotCtl  out  8  motor control register to BOTSIM
- stale  out  1  watchdog state is STALE
- ovf  out  1  sticky: a snapshot was dropped
- ovf_clr  in  1  clears ovf and drop_cnt
- drop_cnt  out  8  dropped snapshots, saturating at 255
- upd_cnt  out  16  accepted updates, wrapping

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO emptied; snap_valid=0; snap_data=0.
  - MotCtl=0; mot_reg=0.
  - State RUN; watchdog timer=0; stale=0.
  - ovf=0; drop_cnt=0; upd_cnt=0.
  - upd_q <= upd_sysregs, so there is no false push on reset exit.
- Update detect:
  - upd_evt = upd_sysregs ^ upd_q; upd_q <= upd_sysregs every cycle.
  - On an edge with upd_evt=1, the push data is the LocX/LocY/BotInfo/Sensors values sampled at that same edge.
- FIFO:
  - A push on edge N gives snap_valid=1 after edge N if the FIFO was empty. There is no combinational fall-through.
  - Pop occurs on an edge with snap_valid & snap_ready. snap_data is stable while snap_valid=1 and no pop occurs.
  - Full with push and no pop: the new snapshot is dropped; ovf<=1; drop_cnt increments, saturating; FIFO contents unchanged.
  - Full with push and pop on the same edge: both take effect; no drop.
  - Empty with pop: impossible, since snap_valid=0.
  - Pointers wrap modulo DEPTH; a count register of width log2(DEPTH)+1 distinguishes full from empty.
- upd_cnt increments on every upd_evt, including dropped snapshots.
- ovf_clr:
  - Clears ovf and drop_cnt.
  - If a drop occurs on the same edge, the drop wins: ovf=1, drop_cnt=1.
- Watchdog FSM, states RUN and STALE:
  - RUN: the timer increments each cycle and resets to 0 on upd_evt. When the timer reaches TIMEOUT-1 with no upd_evt, go to STALE and clear mot_reg to 0.
  - STALE: stale=1. On upd_evt, go to RUN with timer=0.
- Motor register:
  - mot_cmd_wr=1 loads mot_reg <= mot_cmd on that edge, in either state.
  - MotCtl <= (next state is STALE) ? 0 : next mot_reg, registered, so there is a one-cycle latency from write to MotCtl.
  - Entering STALE together with mot_cmd_wr on the same edge: the write wins in mot_reg, but MotCtl=0 until the FSM returns to RUN.
  - On returning to RUN, MotCtl shows mot_reg, which is 0 unless a command was written during STALE.
- All outputs are registered. No combinational path from inputs to outputs except snap_valid/snap_data, which come from registers.

Decomposition:
- Include file botsys_defs.vh:
  - Snapshot field bit positions (SNAP_LOCX_HI/LO, etc.).
  - MotCtl field positions.
  - MOT_STOP = 8'h00.
  - FSM state encodings ST_RUN and ST_STALE.
- One sub-module, snap_fifo: a generic synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty/count.
- The top level holds the toggle detect, counters, watchdog FSM and motor register.

Test Plan:
- Reset, then 3 toggles of upd_sysregs with LocX=10/11/12, LocY=20, BotInfo=8'h03, Sensors=8'h18, and snap_ready=1 -> 3 snapshots in order; first snap_data=32'h0A140318; upd_cnt=3; ovf=0.
- snap_ready=0, DEPTH=4, 6 toggles -> the first 4 are retained; ovf=1; drop_cnt=2; upd_cnt=6. Then pulse ovf_clr -> ovf=0, drop_cnt=0.
- FIFO full, toggle together with snap_ready=1 on the same edge -> no drop; FIFO count stays 4; head advances.
- TIMEOUT=16, mot_cmd_wr with 8'hE7, then no toggles -> MotCtl=8'hE7 one cycle after the write; stale=1 and MotCtl=0 16 cycles after the last update. Then a toggle -> stale=0 and MotCtl=0 until a new mot_cmd_wr.
- Hold upd_sysregs=1 through reset and release -> no snapshot pushed; snap_valid=0; upd_cnt=0.
- Assert reset mid-stream with 2 entries queued and MotCtl=8'h55 -> after the edge, snap_valid=0, MotCtl=0, counters 0.
